// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcode and SYSTEM funct3 encodings, control-unit
// state type and the bundle of strobes the control unit drives.
package otter_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    // funct3 values inside the SYSTEM opcode
    localparam logic [2:0] SYS_PRIV  = 3'b000;  // MRET lives here
    localparam logic [2:0] SYS_CSRRW = 3'b001;
    localparam logic [2:0] SYS_CSRRS = 3'b010;
    localparam logic [2:0] SYS_CSRRC = 3'b011;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } cu_state_t;

    typedef struct packed {
        logic pc_write;
        logic reg_write;
        logic mem_we2;
        logic mem_rden1;
        logic mem_rden2;
        logic csr_we;
        logic int_taken;
        logic mret_exec;
        logic rst_out;
    } cu_strobes_t;

endpackage

// File: rtl/cu_fsm_if.sv
// Control-unit bundle: instruction fields and interrupt request in, commit
// strobes and debug state out. The slave side is the control unit itself.
interface cu_fsm_if;

    logic       INTR;
    logic [6:0] IR_60;
    logic [2:0] IR_1412;
    logic       PC_WRITE;
    logic       REG_WRITE;
    logic       MEM_WE2;
    logic       MEM_RDEN1;
    logic       MEM_RDEN2;
    logic       CSR_WE;
    logic       INT_TAKEN;
    logic       MRET_EXEC;
    logic       RST_OUT;
    logic [2:0] STATE;

    modport master (
        output INTR, IR_60, IR_1412,
        input  PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2,
               CSR_WE, INT_TAKEN, MRET_EXEC, RST_OUT, STATE
    );

    modport slave (
        input  INTR, IR_60, IR_1412,
        output PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2,
               CSR_WE, INT_TAKEN, MRET_EXEC, RST_OUT, STATE
    );

endinterface

// File: rtl/cu_fsm.sv
// OTTER multicycle control unit. Walks each instruction through FETCH (held
// FETCH_WAIT extra cycles), EXEC, an optional load writeback and interrupt
// entry, and decides in which cycle each datapath write commits.
module cu_fsm
    import otter_pkg::*;
#(
    parameter int unsigned FETCH_WAIT = 0   // 0..7 instruction-memory wait states
) (
    input  logic     CLK,
    input  logic     RST,
    cu_fsm_if.slave  bus
);

    localparam logic [2:0] WAIT_LAST = 3'(FETCH_WAIT);

    cu_state_t   state_q;
    cu_state_t   state_d;
    logic [2:0]  wait_cnt;
    logic        fetch_done;
    cu_strobes_t str;

    assign fetch_done = (wait_cnt == WAIT_LAST);

    // State register and fetch wait counter; counter sits at zero outside FETCH
    // so every FETCH entry starts counting from 0.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_INIT;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && !fetch_done) begin
                wait_cnt <= wait_cnt + 3'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Next-state selection and Mealy strobe decode; reset overrides all strobes.
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = ST_INIT;          // illegal encodings recover through INIT
        str     = '0;
        case (state_q)
            ST_INIT: begin
                str.rst_out = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_FETCH: begin
                str.mem_rden1 = 1'b1;
                state_d       = fetch_done ? ST_EXEC : ST_FETCH;
            end
            ST_EXEC: begin
                state_d = bus.INTR ? ST_INTR : ST_FETCH;
                case (bus.IR_60)
                    OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        str.pc_write  = 1'b1;
                        str.reg_write = 1'b1;
                    end
                    OP_LOAD: begin
                        // PC holds until the loaded word is written back
                        str.mem_rden2 = 1'b1;
                        state_d       = ST_WB;
                    end
                    OP_STORE: begin
                        str.mem_we2  = 1'b1;
                        str.pc_write = 1'b1;
                    end
                    OP_SYS: begin
                        str.pc_write = 1'b1;
                        case (bus.IR_1412)
                            SYS_PRIV: str.mret_exec = 1'b1;
                            SYS_CSRRW, SYS_CSRRS, SYS_CSRRC: begin
                                str.csr_we    = 1'b1;
                                str.reg_write = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    // branches and unknown opcodes only advance the PC
                    default: str.pc_write = 1'b1;
                endcase
            end
            ST_WB: begin
                str.reg_write = 1'b1;
                str.pc_write  = 1'b1;
                state_d       = bus.INTR ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                str.int_taken = 1'b1;
                str.pc_write  = 1'b1;
                state_d       = ST_FETCH;
            end
            default: state_d = ST_INIT;
        endcase

        if (RST) begin
            str         = '0;
            str.rst_out = 1'b1;
        end
    end

    assign bus.PC_WRITE  = str.pc_write;
    assign bus.REG_WRITE = str.reg_write;
    assign bus.MEM_WE2   = str.mem_we2;
    assign bus.MEM_RDEN1 = str.mem_rden1;
    assign bus.MEM_RDEN2 = str.mem_rden2;
    assign bus.CSR_WE    = str.csr_we;
    assign bus.INT_TAKEN = str.int_taken;
    assign bus.MRET_EXEC = str.mret_exec;
    assign bus.RST_OUT   = str.rst_out;
    assign bus.STATE     = state_q;

endmodule

// File: doc/cu_fsm.md
Name: cu_fsm

Overview:
- Multicycle control-unit state machine for the OTTER RV32I core.
- Sequences each instruction through fetch, execute, optional load writeback, and interrupt entry.
- Drives the write and read strobes for the PC, register file, memory and CSR file.
- Raises INT_TAKEN toward the cu decoder; the decoder selects data paths, this block decides when they commit.

Parameters:
- FETCH_WAIT, 0, number of extra cycles FETCH is held (instruction-memory wait states), range 0..7.

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- INTR  in  1  interrupt request, already gated by MIE in the CSR file; level-sensitive
- IR_60  in  7  opcode field of the current instruction register
- IR_1412  in  3  funct3 field of the current instruction register
- PC_WRITE  out  1  PC register load enable
- REG_WRITE  out  1  register file write enable
- MEM_WE2  out  1  data memory write enable
- MEM_RDEN1  out  1  instruction memory read enable
- MEM_RDEN2  out  1  data memory read enable
- CSR_WE  out  1  CSR file write enable
- INT_TAKEN  out  1  interrupt entry strobe (to decoder, CSR file)
- MRET_EXEC  out  1  MRET commit strobe (to CSR file)
- RST_OUT  out  1  reset to PC and datapath
- STATE  out  3  current state encoding (debug)

Behaviour:
- States: ST_INIT=0, ST_FETCH=1, ST_EXEC=2, ST_WB=3, ST_INTR=4. Encodings 5–7 are illegal and go to ST_INIT on the next edge.
- Reset:
  - RST high at an edge: state goes to ST_INIT and the wait counter clears.
  - While RST is high, combinationally RST_OUT=1 and every other strobe is 0, whatever the state. No store or register write can leak during reset.
- ST_INIT: RST_OUT=1, all else 0. Next state ST_FETCH unconditionally.
- ST_FETCH:
  - MEM_RDEN1=1, all else 0.
  - Wait counter counts up from 0 each entry.
  - Leave for ST_EXEC when counter==FETCH_WAIT, so FETCH lasts FETCH_WAIT+1 cycles.
  - INTR is ignored in this state.
- ST_EXEC: outputs decoded from IR_60/IR_1412 (Mealy).
  - 0110011 R, 0010011 I, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR: PC_WRITE=1, REG_WRITE=1.
  - 0000011 LOAD: MEM_RDEN2=1, PC_WRITE=0, REG_WRITE=0. Next state ST_WB.
  - 0100011 STORE: MEM_WE2=1, PC_WRITE=1.
  - 1100011 BRANCH: PC_WRITE=1 only. The decoder's PC_SOURCE resolves taken/not-taken.
  - 1110011 SYSTEM, by funct3:
    - 000: MRET_EXEC=1, PC_WRITE=1.
    - 001/010/011: CSR_WE=1, REG_WRITE=1, PC_WRITE=1.
    - Others: PC_WRITE=1 only.
  - Any other opcode: PC_WRITE=1 only (illegal instructions execute as NOP, no trap).
  - Next state for non-LOAD opcodes: ST_INTR if INTR, else ST_FETCH.
- ST_WB: REG_WRITE=1, PC_WRITE=1. Next state ST_INTR if INTR, else ST_FETCH.
- ST_INTR:
  - INT_TAKEN=1, PC_WRITE=1 (PC loads MTVEC via decoder).
  - Next state ST_FETCH unconditionally. INTR is not sampled here.
  - The CSR file clears MIE on INT_TAKEN, so INTR falls before the next EXEC.
- Interrupt sampling:
  - Only at the final cycle of an instruction (EXEC non-load, or WB).
  - The current instruction always completes before entry.
- MRET with INTR high in the same EXEC cycle: MRET commits (MRET_EXEC=1), then ST_INTR follows.
- Latency: a non-load instruction takes FETCH_WAIT+2 cycles; a load takes FETCH_WAIT+3; interrupt entry adds 1.
- At most one of MEM_WE2, MEM_RDEN2 and MEM_RDEN1 is ever high.
- STATE mirrors the state register.

Decomposition:
- Shared package otter_pkg holds:
  - Opcode localparams: OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYS.
  - The SYS funct3 constants.
  - typedef enum logic [2:0] cu_state_t.
- Single module; the wait counter and output decode stay inline, so no sub-module.

Test Plan:
- Reset release: hold RST 2 cycles, then drop it, FETCH_WAIT=0 → STATE sequence 0,1,2; RST_OUT high only in ST_INIT and while RST is high.
- ADD (IR_60=0110011), INTR=0 → EXEC cycle has PC_WRITE=1 and REG_WRITE=1; next STATE=1; each instruction takes 2 cycles.
- LW (0000011) → EXEC: MEM_RDEN2=1, PC_WRITE=0; WB: REG_WRITE=1, PC_WRITE=1; then FETCH. SW (0100011) → MEM_WE2=1 for one cycle only.
- INTR raised mid-FETCH during ADD → EXEC commits, then ST_INTR with INT_TAKEN=1 for exactly 1 cycle, then FETCH. With a load, ST_INTR follows WB.
- CSRRW (1110011, funct3=001) → CSR_WE=1 and REG_WRITE=1 in EXEC. MRET (funct3=000) with INTR=1 → MRET_EXEC=1, then INT_TAKEN=1 the next cycle.
- FETCH_WAIT=3 → MEM_RDEN1 high for 4 consecutive cycles; RST asserted during EXEC of SW → MEM_WE2=0 that cycle and STATE=0 next edge.
